// File: rtl/pc_fetch_unit_if.sv
// Fetch request channel between the PC generator (master) and instruction memory (slave).
// The master offers pc with fetch_valid, and the slave takes it on a cycle where fetch_ready is high.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;

    modport master (
        output fetch_valid,
        output pc,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        output fetch_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: stall, redirect, trap, halt/resume and a saturating fetch counter. PC_RAS_EN adds a return-address stack.
// Latency: every update lands on the edge after its inputs are sampled, and pc/fetch_valid come straight from flops.
// Backpressure: pc and fetch_valid hold while fetch_ready is low or stall is high. Redirects and traps override both.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              CNT_W        = 16,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  trap_valid,
    input  logic                  halt_req,
    input  logic                  resume,
    input  logic                  call_valid,
    input  logic                  ret_valid,
    pc_fetch_unit_if.master       fetch,
    output logic [XLEN-1:0]       epc,
    output logic                  misalign_err,
    output logic [CNT_W-1:0]      fetch_count,
    output logic                  ras_empty
);

    localparam logic [XLEN-1:0] INC       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] OFFS_MASK = XLEN'(INSTR_BYTES - 1);

    if (RAS_DEPTH < 1 || INSTR_BYTES < 1 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_param_check
        $error("pc_fetch_unit: INSTR_BYTES must be a power of 2 and RAS_DEPTH >= 1");
    end

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic             fv_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  pc_inc;
    logic             accept;
    logic             redir_sel;
    logic             misalign_nxt;
    logic             ras_has;
    logic [XLEN-1:0]  ras_top;

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RCW   = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_wp;
    logic [PTR_W-1:0] ras_wp_inc;
    logic [PTR_W-1:0] ras_wp_dec;
    logic [RCW-1:0]   ras_cnt;
    logic             ras_push;
    logic             ras_pop;
`endif

    assign fetch.pc          = pc_q;
    assign fetch.fetch_valid = fv_q;
    assign pc_inc            = pc_q + INC;
    assign accept            = fv_q & fetch.fetch_ready & ~stall;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (halt_req) state_nxt = ST_HALT;
            ST_HALT: if (resume)   state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Trap beats return beats call beats redirect beats sequential advance.
    always_comb begin
        pc_nxt    = pc_q;
        redir_sel = 1'b0;
`ifdef PC_RAS_EN
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
`endif
        if (trap_valid) begin
            pc_nxt = TRAP_VECTOR;
        end else if (ret_valid) begin
            if (ras_has) begin
                pc_nxt = ras_top;
`ifdef PC_RAS_EN
                ras_pop = 1'b1;
`endif
            end else begin
                redir_sel = 1'b1;
            end
        end else if (call_valid) begin
            redir_sel = 1'b1;
`ifdef PC_RAS_EN
            ras_push  = 1'b1;
`endif
        end else if (redirect_valid) begin
            redir_sel = 1'b1;
        end else if (accept) begin
            pc_nxt = pc_inc;
        end
        if (redir_sel) begin
            pc_nxt = redirect_target & ~OFFS_MASK;
        end
        misalign_nxt = redir_sel & (|(redirect_target & OFFS_MASK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            fv_q         <= 1'b0;
            pc_q         <= RESET_VECTOR;
            epc          <= '0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state_q      <= state_nxt;
            fv_q         <= (state_nxt == ST_RUN);
            pc_q         <= pc_nxt;
            misalign_err <= misalign_nxt;
            if (trap_valid) begin
                epc <= pc_q;
            end
            // A request that was accepted is counted even when a redirect replaces the next pc.
            if (accept && (fetch_count != {CNT_W{1'b1}})) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

`ifdef PC_RAS_EN
    assign ras_wp_inc = (ras_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wp + 1'b1;
    assign ras_wp_dec = (ras_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wp - 1'b1;
    assign ras_top    = ras_mem[ras_wp_dec];
    assign ras_has    = (ras_cnt != '0);
    assign ras_empty  = ~ras_has;

    // Circular stack: a push when full overwrites the oldest entry, and the count saturates at depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (ras_push) begin
            ras_mem[ras_wp] <= pc_inc;
            ras_wp          <= ras_wp_inc;
            if (ras_cnt != RCW'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (ras_pop) begin
            ras_wp  <= ras_wp_dec;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
`else
    assign ras_has   = 1'b0;
    assign ras_top   = pc_inc;
    assign ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit. Expected values are hand-computed for XLEN=32, INSTR_BYTES=4.
// With PC_RAS_EN defined, the return-stack vectors expect stack behaviour. Otherwise they expect plain redirects.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt_req;
    logic        resume;
    logic        call_valid;
    logic        ret_valid;
    logic [31:0] epc;
    logic        misalign_err;
    logic [15:0] fetch_count;
    logic        ras_empty;

    int n_vec  = 0;
    int n_miss = 0;

    pc_fetch_unit_if #(.XLEN(32)) fif ();

    pc_fetch_unit #(
        .XLEN        (32),
        .INSTR_BYTES (4),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .CNT_W       (16),
        .RAS_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .halt_req       (halt_req),
        .resume         (resume),
        .call_valid     (call_valid),
        .ret_valid      (ret_valid),
        .fetch          (fif.master),
        .epc            (epc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .ras_empty      (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h1304;
        ret_exp[1] = 32'h1204;
        ret_exp[2] = 32'h1104;
        ret_exp[3] = 32'h1004;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        call_valid = 1'b0; ret_valid = 1'b0; fif.fetch_ready = 1'b0;

        // Reset, the boot cycle, and then sequential fetch.
        tick(); tick();
        check_eq("rst_pc", fif.pc, 32'h0);
        check_eq("rst_fv", fif.fetch_valid, 1'b0);
        check_eq("rst_epc", epc, 32'h0);
        check_eq("rst_mis", misalign_err, 1'b0);
        check_eq("rst_cnt", fetch_count, 16'd0);
        check_eq("rst_ras_empty", ras_empty, 1'b1);
        rst = 1'b0; fif.fetch_ready = 1'b1;
        tick();
        check_eq("boot_pc", fif.pc, 32'h0);
        check_eq("boot_fv", fif.fetch_valid, 1'b1);
        tick();
        check_eq("seq_pc4", fif.pc, 32'h4);
        tick();
        check_eq("seq_pc8", fif.pc, 32'h8);
        check_eq("seq_cnt2", fetch_count, 16'd2);

        // Backpressure from fetch_ready, then from stall.
        fif.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("nordy_pc", fif.pc, 32'h8);
            check_eq("nordy_fv", fif.fetch_valid, 1'b1);
        end
        fif.fetch_ready = 1'b1; stall = 1'b1;
        tick();
        check_eq("stall_pc", fif.pc, 32'h8);
        check_eq("stall_cnt", fetch_count, 16'd2);
        stall = 1'b0;
        tick();
        check_eq("seq_pc12", fif.pc, 32'hC);
        check_eq("seq_cnt3", fetch_count, 16'd3);

        // A misaligned redirect that coincides with an accept still counts the accept.
        redirect_to(32'h203);
        fif.fetch_ready = 1'b0;
        check_eq("redir_pc", fif.pc, 32'h200);
        check_eq("redir_mis", misalign_err, 1'b1);
        check_eq("redir_cnt", fetch_count, 16'd4);
        tick();
        check_eq("mis_pulse_end", misalign_err, 1'b0);
        redirect_to(32'h200);
        check_eq("redir_al_pc", fif.pc, 32'h200);
        check_eq("redir_al_mis", misalign_err, 1'b0);

        // A trap beats a simultaneous redirect, then the pc wraps at the top of the address space.
        redirect_to(32'h40);
        trap_valid = 1'b1;
        redirect_to(32'h83);
        trap_valid = 1'b0;
        check_eq("trap_pc", fif.pc, 32'h100);
        check_eq("trap_epc", epc, 32'h40);
        check_eq("trap_mis", misalign_err, 1'b0);
        redirect_to(32'hFFFF_FFFC);
        fif.fetch_ready = 1'b1;
        tick();
        fif.fetch_ready = 1'b0;
        check_eq("wrap_pc", fif.pc, 32'h0);
        check_eq("wrap_cnt", fetch_count, 16'd5);

        // Halt, a redirect while halted, and resume.
        redirect_to(32'h10);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_eq("halt_fv", fif.fetch_valid, 1'b0);
        check_eq("halt_pc", fif.pc, 32'h10);
        fif.fetch_ready = 1'b1;
        tick();
        check_eq("halt_hold_pc", fif.pc, 32'h10);
        check_eq("halt_hold_cnt", fetch_count, 16'd5);
        redirect_to(32'h80);
        check_eq("halt_redir_pc", fif.pc, 32'h80);
        check_eq("halt_redir_fv", fif.fetch_valid, 1'b0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check_eq("resume_fv", fif.fetch_valid, 1'b1);
        check_eq("resume_pc", fif.pc, 32'h80);
        tick();
        check_eq("resume_adv_pc", fif.pc, 32'h84);
        check_eq("resume_adv_cnt", fetch_count, 16'd6);
        fif.fetch_ready = 1'b0;

        // Call and return paths.
        redirect_to(32'h20);
        call_valid = 1'b1; redirect_target = 32'h400;
        tick();
        call_valid = 1'b0;
        check_eq("call_pc", fif.pc, 32'h400);
`ifdef PC_RAS_EN
        check_eq("call_ras_empty", ras_empty, 1'b0);
`else
        check_eq("call_ras_empty", ras_empty, 1'b1);
`endif
        ret_valid = 1'b1; redirect_target = 32'h30;
        tick();
        ret_valid = 1'b0;
`ifdef PC_RAS_EN
        check_eq("ret_pc", fif.pc, 32'h24);
`else
        check_eq("ret_pc", fif.pc, 32'h30);
`endif
        check_eq("ret_ras_empty", ras_empty, 1'b1);

        for (int i = 0; i < 5; i++) begin
            call_valid = 1'b1;
            redirect_target = 32'h1000 + 32'h100 * i;
            tick();
        end
        call_valid = 1'b0;
        check_eq("calls_pc", fif.pc, 32'h1400);
        ret_valid = 1'b1; redirect_target = 32'hBAD0;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef PC_RAS_EN
            check_eq("ret_deep_pc", fif.pc, {32'h0, ret_exp[i]});
`else
            check_eq("ret_deep_pc", fif.pc, 32'hBAD0);
`endif
        end
        check_eq("ret_deep_empty", ras_empty, 1'b1);
        redirect_target = 32'h555;
        tick();
        ret_valid = 1'b0;
        check_eq("ret_empty_pc", fif.pc, 32'h554);
        check_eq("ret_empty_mis", misalign_err, 1'b1);

        // A reset in the middle of operation discards all state.
        rst = 1'b1; fif.fetch_ready = 1'b1;
        tick();
        check_eq("rst2_pc", fif.pc, 32'h0);
        check_eq("rst2_fv", fif.fetch_valid, 1'b0);
        check_eq("rst2_cnt", fetch_count, 16'd0);
        check_eq("rst2_epc", epc, 32'h0);
        check_eq("rst2_ras_empty", ras_empty, 1'b1);
        rst = 1'b0;
        tick();
        check_eq("rst2_boot_fv", fif.fetch_valid, 1'b1);
        check_eq("rst2_boot_pc", fif.pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
